uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver; front stage of the UART–ALU path.
- Oversamples the asynchronous line, deframes 8N1 characters and presents each byte with a one-cycle done strobe.
- Output pair o_rx_data/o_rx_done feeds the command interface directly.
- Oversample strobe i_tick comes from the shared baud-rate generator.

Parameters:
- NB_DATA, 8, data bits per character, LSB transmitted first.
- N_OVERSAMPLE, 16, i_tick pulses per bit period; power of two, ≥ 8.
- SB_TICK, 16, i_tick pulses spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous serial line; idles high.
- i_tick  input  1  oversample enable, one i_clk wide, N_OVERSAMPLE per bit.
- o_rx_data  output  NB_DATA  last received byte; stable between done pulses.
- o_rx_done  output  1  one-cycle strobe, byte valid on o_rx_data.
- o_frame_err  output  1  one-cycle strobe coincident with o_rx_done when the stop bit sampled low.

Behaviour:
- Reset, checked every posedge i_clk:
  - state=IDLE; tick counter=0; bit counter=0; shift register=0.
  - o_rx_data=0; o_rx_done=0; o_frame_err=0.
  - Both synchronizer flops=1.
- Reset asserted mid-character aborts it; no done strobe is issued for the partial byte.
- Input: i_rx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s, so the line has 2 i_clk of latency.
- State machine: IDLE, START, DATA, STOP. Counters advance only on cycles where i_tick=1. State changes other than IDLE->START occur only on tick cycles.
- IDLE:
  - rx_s=0 on any clock, tick not required: go to START, tick counter=0.
- START:
  - On a tick with counter = N_OVERSAMPLE/2−1, i.e. mid start bit:
    - rx_s=0: go to DATA, tick counter=0, bit counter=0.
    - rx_s=1: glitch; return to IDLE with no outputs.
  - Otherwise increment the counter on each tick.
- DATA:
  - On a tick with counter = N_OVERSAMPLE−1:
    - Sample rx_s into the MSB of the shift register (shift right), so the first bit lands in bit 0 after NB_DATA shifts.
    - Counter=0; increment the bit counter.
  - After the sample where bit counter = NB_DATA−1, go to STOP.
- STOP:
  - On a tick with counter = SB_TICK−1, sample rx_s.
  - Next clock: o_rx_data ← shift register, o_rx_done=1 for exactly one cycle, o_frame_err=1 if the sample was 0.
  - Return to IDLE.
- Framing errors still deliver the byte.
- If the line is held low after a framing error, IDLE immediately re-arms on rx_s=0, i.e. a new START. This is intended; the bench must tolerate back-to-back errors.
- o_rx_data changes only in the done cycle; otherwise it holds.
- i_tick absent: FSM freezes in its current state indefinitely; no timeout.
- Back-to-back frames: the next start edge may be detected the clock after the STOP→IDLE transition; no gap is required beyond the stop bit.
- Counter widths: ceil(log2(max(N_OVERSAMPLE, SB_TICK))) for the tick counter; ceil(log2(NB_DATA))+1 for the bit counter. Neither counter ever wraps in normal operation.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled at counter = N_OVERSAMPLE−1.
  - Even parity is checked over the data bits plus the parity bit.
  - Adds port o_parity_err (output, 1), a one-cycle strobe coincident with o_rx_done on mismatch; reset value 0.
  - The byte is still delivered on error.
- Undefined: no PARITY state, no o_parity_err port; pure 8N1 framing.

Test Plan:
- Setup: tick every 4 clk, N_OVERSAMPLE=16 (64 clk per bit).
- Send 0xA5, 8N1 → o_rx_done exactly one cycle, o_rx_data=0xA5, o_frame_err=0; done occurs 1–3 clk after stop-bit mid-sample.
- Send 0x00, then 0xFF with zero idle gap → two done strobes, data 0x00 then 0xFF, no errors.
- Start-bit glitch: i_rx low for 20 clk, then high → no done strobe, FSM back in IDLE. A following 0x3C is received correctly.
- Framing error: send 0x81 with stop bit driven low → done with o_rx_data=0x81 and o_frame_err=1 in the same cycle.
- Reset mid-byte: assert i_reset for 1 clk during bit 4 of 0x55 → no done strobe, o_rx_data=0. A subsequent 0x55 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 → o_parity_err=1, data 0x07. With parity bit 1 → o_parity_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : oversampling UART receiver, front stage of the UART-ALU path.
//
// The asynchronous line is brought into the i_clk domain through a 2-flop
// synchronizer. An IDLE/START/DATA/STOP state machine, advanced by the shared
// oversample strobe i_tick, then deframes LSB-first characters. A receiver
// that is running but sees no ticks stays in its current state.
//
// Optional feature, enabled by defining UART_RX_PARITY_EN:
//   adds a PARITY state between DATA and STOP (even parity over data + parity
//   bit) and the o_parity_err output.
//
// Parameters:
//   NB_DATA      data bits per character, LSB first
//   N_OVERSAMPLE i_tick pulses per bit period (power of two, >= 8)
//   SB_TICK      i_tick pulses spanning the stop bit (16/24/32)
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_rx         asynchronous serial line, idles high
//   i_tick       oversample enable, one i_clk wide
//   o_rx_data    last received byte, held between done pulses
//   o_rx_done    one-cycle strobe, o_rx_data valid
//   o_frame_err  one-cycle strobe with o_rx_done when the stop bit sampled low
//   o_parity_err one-cycle strobe with o_rx_done on parity mismatch
//                (UART_RX_PARITY_EN only)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int NB_DATA      = 8,
  parameter int N_OVERSAMPLE = 16,
  parameter int SB_TICK      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic               o_parity_err
`endif
);

  localparam int TICK_MAX = (N_OVERSAMPLE > SB_TICK) ? N_OVERSAMPLE : SB_TICK;
  localparam int TW       = $clog2(TICK_MAX);
  localparam int BW       = $clog2(NB_DATA) + 1;

  // Tick-count values at which each state acts. The start bit is checked at
  // its middle; every later sample is one full bit period after the previous
  // one, so all samples land mid-bit.
  localparam logic [TW-1:0] MID_START = TW'(N_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(N_OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_END  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [NB_DATA-1:0]   shift_reg, shift_n;
  logic [NB_DATA-1:0]   data_n;
  logic                 done_n;
  logic                 ferr_n;
  logic                 rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit, parity_n;
  logic                 perr_n;
`endif

  // ---------------------------------------------------------------------------
  // Line synchronizer. Both flops reset to the idle level so that reset does
  // not look like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; rx_s gets the old rx_meta, not the new one.
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: the shift register is ordinary flops, so it is reset along with
    // the rest of the state; a reset mid-character discards the partial byte.
    if (i_reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shift_reg   <= shift_n;
      o_rx_data   <= data_n;
      o_rx_done   <= done_n;
      o_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= parity_n;
      o_parity_err <= perr_n;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold/idle default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    data_n  = o_rx_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_n = parity_bit;
    perr_n   = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        // Start edge is taken on any clock; ticks only pace the later states.
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (tick_cnt == MID_START) begin
            if (!rx_s) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (tick_cnt == BIT_END) begin
            tick_n  = '0;
            // Shift right, new bit enters at the MSB: the first (LSB) bit
            // ends up in bit 0 after NB_DATA samples.
            shift_n = {rx_s, shift_reg[NB_DATA-1:1]};
            bit_n   = bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_cnt == BIT_END) begin
            tick_n   = '0;
            parity_n = rx_s;
            state_n  = STOP;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (i_tick) begin
          if (tick_cnt == STOP_END) begin
            // The byte is delivered even on a framing/parity error.
            state_n = IDLE;
            data_n  = shift_reg;
            done_n  = 1'b1;
            ferr_n  = !rx_s;
`ifdef UART_RX_PARITY_EN
            // Even parity: total number of ones, parity bit included, is even.
            perr_n  = ^{shift_reg, parity_bit};
`endif
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx.
//
// i_tick pulses every 4 clocks with 16x oversampling, so one bit is 64 clocks.
// Each sent frame is recorded in an expected queue (data, framing/parity
// error, start cycle). A monitor pops one entry per o_rx_done strobe and
// checks data, error flags, strobe width and when the strobe arrives
// relative to the middle of the stop bit. Scenario tasks check that every
// frame was delivered and that nothing extra appeared.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS_BEFORE_STOP = 10;  // start + 8 data + parity
`else
  localparam int NBITS_BEFORE_STOP = 9;   // start + 8 data
`endif
  // Middle of the stop bit, in clocks after the start edge was driven.
  localparam int STOP_MID = NBITS_BEFORE_STOP * BIT_CLK + BIT_CLK / 2;
  // Allowed offset of the done strobe around the stop mid-point: 2 clk of
  // synchronizer, 1 clk to leave IDLE, up to 4 clk tick quantization.
  localparam int WIN_LO = -2;
  localparam int WIN_HI = 6;

  typedef struct {
    logic [7:0]  data;
    logic        ferr;
    logic        perr;
    int unsigned cyc;
  } frame_t;

  logic       clk;
  logic       i_reset;
  logic       i_rx;
  logic       i_tick;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       parity_err;

  frame_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int unsigned cyc      = 0;
  logic        rst_at_edge = 1'b1;
  logic        hold_bad    = 1'b0;

  uart_rx #(
    .NB_DATA      (8),
    .N_OVERSAMPLE (16),
    .SB_TICK      (16)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .i_tick       (i_tick),
    .o_rx_data    (o_rx_data),
    .o_rx_done    (o_rx_done),
    .o_frame_err  (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (parity_err)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_at_edge = i_reset;
    end
  end

  // Oversample strobe: one clock high out of every four.
  initial begin
    int div;
    div    = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      i_tick = (div == 0);
    end
  end

  // Scoreboard monitor.
  initial begin
    frame_t     e;
    logic       prev_done;
    logic [7:0] last_data;
    int         dt;
    prev_done = 1'b0;
    last_data = 8'h00;
    forever begin
      @(negedge clk);
      if (o_rx_done) begin
        n_done++;
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL done_width: o_rx_done high on consecutive cycles at cyc %0d, required 1 cycle", cyc);
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got data=%02h ferr=%0b at cyc %0d, required no strobe",
                   o_rx_data, o_frame_err, cyc);
        end else begin
          e  = exp_q.pop_front();
          dt = int'(cyc - e.cyc) - STOP_MID;
          n_checks++;
          if (o_rx_data !== e.data) begin
            n_fail++;
            $display("FAIL rx_data: got %02h, required %02h", o_rx_data, e.data);
          end
          n_checks++;
          if (o_frame_err !== e.ferr) begin
            n_fail++;
            $display("FAIL frame_err (data %02h): got %0b, required %0b", e.data, o_frame_err, e.ferr);
          end
          n_checks++;
          if (parity_err !== e.perr) begin
            n_fail++;
            $display("FAIL parity_err (data %02h): got %0b, required %0b", e.data, parity_err, e.perr);
          end
          n_checks++;
          if (dt < WIN_LO || dt > WIN_HI) begin
            n_fail++;
            $display("FAIL done_latency (data %02h): done %0d clk from stop mid, required %0d..%0d",
                     e.data, dt, WIN_LO, WIN_HI);
          end
        end
      end else if (!o_frame_err !== 1'b1 || parity_err !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL err_strobe: error flag high without o_rx_done at cyc %0d", cyc);
      end
      if (!o_rx_done && !rst_at_edge && o_rx_data !== last_data) hold_bad = 1'b1;
      last_data = o_rx_data;
      prev_done = o_rx_done;
    end
  end

  // Global time limit.
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation time limit reached, required bench to finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All of them start and end on a negedge.
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one character and records what the receiver must report.
  // A bad stop bit is held low for 48 clk only (past its mid sample, then
  // high) so the re-armed START sees a glitch rather than a new frame.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par);
    frame_t e;
    e.data = d;
    e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
    e.perr = (^d) ^ par;
`else
    e.perr = 1'b0;
`endif
    e.cyc  = cyc;
    exp_q.push_back(e);
    i_rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = par;
    repeat (BIT_CLK) @(negedge clk);
`endif
    if (stop_ok) begin
      i_rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      i_rx = 1'b0;
      repeat (48) @(negedge clk);
      i_rx = 1'b1;
      repeat (BIT_CLK - 48) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios.
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    i_reset = 1'b1;
    i_rx    = 1'b0;  // line low during reset must not matter
    repeat (5) @(negedge clk);
    n_checks++;
    if (o_rx_data !== 8'h00 || o_rx_done !== 1'b0 || o_frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%02h done=%0b ferr=%0b perr=%0b, required all 0",
               o_rx_data, o_rx_done, o_frame_err, parity_err);
    end
    i_rx    = 1'b1;
    i_reset = 1'b0;
    idle(100);
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: %0d done strobes after reset, required 0", n_done);
    end
  endtask

  task automatic test_single;
    int d0;
    d0 = n_done;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(150);
    n_checks++;
    if (n_done - d0 !== 1) begin
      n_fail++;
      $display("FAIL single_count: %0d strobes for 0xA5, required 1", n_done - d0);
    end
    n_checks++;
    if (o_rx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_hold: o_rx_data=%02h after frame, required a5", o_rx_data);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = n_done;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(150);
    n_checks++;
    if (n_done - d0 !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: %0d strobes, %0d pending, required 2 and 0", n_done - d0, exp_q.size());
    end
  endtask

  task automatic test_glitch;
    int d0;
    d0 = n_done;
    i_rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(200);
    n_checks++;
    if (n_done !== d0) begin
      n_fail++;
      $display("FAIL glitch: %0d strobes after start glitch, required 0", n_done - d0);
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(150);
    n_checks++;
    if (n_done - d0 !== 1 || o_rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL glitch_recover: %0d strobes data=%02h, required 1 and 3c", n_done - d0, o_rx_data);
    end
  endtask

  task automatic test_framing;
    int d0;
    d0 = n_done;
    send_frame(8'h81, 1'b0, 1'b0);
    idle(200);
    send_frame(8'h81, 1'b0, 1'b0);  // a second error right after the first
    idle(200);
    n_checks++;
    if (n_done - d0 !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL framing_count: %0d strobes, %0d pending, required 2 and 0", n_done - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = n_done;
    i_rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_rx = i[0] ? 1'b0 : 1'b1;  // 0x55 LSB first: 1,0,1,0
      repeat (BIT_CLK) @(negedge clk);
    end
    i_rx = 1'b1;                  // bit 4
    repeat (BIT_CLK / 2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    idle(700);                    // the aborted frame is not continued
    n_checks++;
    if (n_done !== d0) begin
      n_fail++;
      $display("FAIL reset_mid_done: %0d strobes after mid-byte reset, required 0", n_done - d0);
    end
    n_checks++;
    if (o_rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_data: o_rx_data=%02h, required 00", o_rx_data);
    end
    send_frame(8'h55, 1'b1, 1'b0);
    idle(150);
    n_checks++;
    if (n_done - d0 !== 1 || o_rx_data !== 8'h55) begin
      n_fail++;
      $display("FAIL reset_mid_recover: %0d strobes data=%02h, required 1 and 55", n_done - d0, o_rx_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int d0;
    d0 = n_done;
    send_frame(8'h07, 1'b1, 1'b0);  // three ones + 0: odd total -> error
    send_frame(8'h07, 1'b1, 1'b1);  // three ones + 1: even total -> ok
    idle(150);
    n_checks++;
    if (n_done - d0 !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL parity_count: %0d strobes, %0d pending, required 2 and 0", n_done - d0, exp_q.size());
    end
  endtask
`endif

  task automatic test_random;
    int         d0;
    logic [7:0] d;
    logic       stop_ok;
    logic       par;
    d0 = n_done;
    for (int k = 0; k < 16; k++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      par     = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop_ok, par);
      // After a framing error the receiver re-arms on the low stop bit;
      // give that spurious START time to fall back to IDLE.
      idle(stop_ok ? BIT_CLK * $urandom_range(0, 2) : 2 * BIT_CLK);
    end
    idle(150);
    n_checks++;
    if (n_done - d0 !== 16 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL random_count: %0d strobes, %0d pending, required 16 and 0", n_done - d0, exp_q.size());
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    n_checks++;
    if (hold_bad !== 1'b0) begin
      n_fail++;
      $display("FAIL data_hold: o_rx_data changed outside a done cycle, required stable");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
